// File: rtl/uart_rx.sv
// UART receiver: 8x-oversampled start/data/parity/stop recovery into a one-deep
// receive register with full, framing, parity and overrun status.
module uart_rx #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       bclkx8,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       rdrf,
  output logic       ferr,
  output logic       perr,
  output logic       oerr,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_n;
  logic        bclkx8_d, tick;
  logic        rx_p0, rxs;
  logic [2:0]  sc, sc_n, bc, bc_n;
  logic [7:0]  shreg, shreg_n;
  logic        parbit, parbit_n;
  logic        stop_smp;

  // Nonzero when data plus received parity bit disagree with the selected sense.
  function automatic logic parity_err(input logic [7:0] d, input logic p);
    return PARITY_EN ? (^d ^ p ^ PARITY_ODD) : 1'b0;
  endfunction

  assign tick = bclkx8 & ~bclkx8_d;
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    sc_n     = sc;
    bc_n     = bc;
    shreg_n  = shreg;
    parbit_n = parbit;
    stop_smp = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            sc_n    = 3'd0;
            state_n = START;
          end
        end
        START: begin
          sc_n = sc + 3'd1;
          if (sc == 3'd3) begin
            if (rxs) begin
              state_n = IDLE;
            end else begin
              sc_n    = 3'd0;
              bc_n    = 3'd0;
              state_n = DATA;
            end
          end
        end
        DATA: begin
          sc_n = sc + 3'd1;
          if (sc == 3'd7) begin
            shreg_n = {rxs, shreg[7:1]};
            bc_n    = bc + 3'd1;
            if (bc == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          sc_n = sc + 3'd1;
          if (sc == 3'd7) begin
            parbit_n = rxs;
            state_n  = STOP;
          end
        end
        STOP: begin
          sc_n = sc + 3'd1;
          if (sc == 3'd7) begin
            stop_smp = 1'b1;
            state_n  = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Sync stage: line synchronizer, strobe edge detect, FSM and receive register
  always_ff @(posedge clk) begin
    if (rstb) begin
      state    <= IDLE;
      sc       <= 3'd0;
      bc       <= 3'd0;
      bclkx8_d <= 1'b0;
      rx_p0    <= 1'b1;
      rxs      <= 1'b1;
      rdata    <= 8'h00;
      rdrf     <= 1'b0;
      ferr     <= 1'b0;
      perr     <= 1'b0;
      oerr     <= 1'b0;
    end else begin
      state    <= state_n;
      sc       <= sc_n;
      bc       <= bc_n;
      bclkx8_d <= bclkx8;
      rx_p0    <= rxd;
      rxs      <= rx_p0;
      if (stop_smp) begin
        // A same-cycle read frees the register, so the new frame still loads.
        if (!rdrf || rd) begin
          rdata <= shreg;
          rdrf  <= 1'b1;
          ferr  <= ~rxs;
          perr  <= parity_err(shreg, parbit);
          if (rd) oerr <= 1'b0;
        end else begin
          oerr <= 1'b1;
        end
      end else if (rd) begin
        rdrf <= 1'b0;
        ferr <= 1'b0;
        perr <= 1'b0;
        oerr <= 1'b0;
      end
    end
  end

  // Shift register and parity capture carry data only; no reset needed.
  always_ff @(posedge clk) begin
    shreg  <= shreg_n;
    parbit <= parbit_n;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (no parity, even, odd) driven by serial
// frames and compared against a frame-level model of the receive register.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       bclkx8 = 1'b0;
  logic [2:0] rxd = 3'b111;
  logic [2:0] rd = 3'b000;
  logic [7:0] rdata [3];
  logic [2:0] rdrf, ferr, perr, oerr, busy;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] m_rdata [3];
  logic [2:0] m_rdrf, m_ferr, m_perr, m_oerr;

  uart_rx #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_rx0 (
    .clk(clk), .rstb(rstb), .bclkx8(bclkx8), .rxd(rxd[0]), .rd(rd[0]),
    .rdata(rdata[0]), .rdrf(rdrf[0]), .ferr(ferr[0]), .perr(perr[0]),
    .oerr(oerr[0]), .busy(busy[0]));

  uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_rx1 (
    .clk(clk), .rstb(rstb), .bclkx8(bclkx8), .rxd(rxd[1]), .rd(rd[1]),
    .rdata(rdata[1]), .rdrf(rdrf[1]), .ferr(ferr[1]), .perr(perr[1]),
    .oerr(oerr[1]), .busy(busy[1]));

  uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_rx2 (
    .clk(clk), .rstb(rstb), .bclkx8(bclkx8), .rxd(rxd[2]), .rd(rd[2]),
    .rdata(rdata[2]), .rdrf(rdrf[2]), .ferr(ferr[2]), .perr(perr[2]),
    .oerr(oerr[2]), .busy(busy[2]));

  always #5 clk = ~clk;

  // 8x strobe: 16 clk period, changes just after a rising clk edge
  initial begin
    forever begin
      repeat (8) @(posedge clk);
      #1 bclkx8 = ~bclkx8;
    end
  end

  function automatic bit has_par(input int i);
    return (i != 0);
  endfunction

  function automatic bit is_odd(input int i);
    return (i == 2);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input int i, input string tag);
    check_val($sformatf("%s_u%0d_rdata", tag, i), 32'(rdata[i]), 32'(m_rdata[i]));
    check_val($sformatf("%s_u%0d_rdrf", tag, i), 32'(rdrf[i]), 32'(m_rdrf[i]));
    check_val($sformatf("%s_u%0d_ferr", tag, i), 32'(ferr[i]), 32'(m_ferr[i]));
    check_val($sformatf("%s_u%0d_perr", tag, i), 32'(perr[i]), 32'(m_perr[i]));
    check_val($sformatf("%s_u%0d_oerr", tag, i), 32'(oerr[i]), 32'(m_oerr[i]));
    check_val($sformatf("%s_u%0d_busy", tag, i), 32'(busy[i]), 32'h0);
  endtask

  // Model: a completed frame loads an empty register, else it is lost (overrun)
  task automatic model_frame(input int i, input logic [7:0] d, input logic pbit, input logic stop);
    logic want_p;
    if (!m_rdrf[i]) begin
      m_rdata[i] = d;
      m_rdrf[i]  = 1'b1;
      m_ferr[i]  = !stop;
      // Even parity: total ones in data+parity is even; odd: total is odd
      want_p     = is_odd(i) ? !(^d) : (^d);
      m_perr[i]  = has_par(i) ? (pbit != want_p) : 1'b0;
    end else begin
      m_oerr[i] = 1'b1;
    end
  endtask

  task automatic model_read(input int i);
    if (m_rdrf[i]) begin
      m_rdrf[i] = 1'b0;
      m_ferr[i] = 1'b0;
      m_perr[i] = 1'b0;
      m_oerr[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_rdata[i] = 8'h00;
    m_rdrf = '0;
    m_ferr = '0;
    m_perr = '0;
    m_oerr = '0;
  endtask

  task automatic drive_bit(input int i, input logic v);
    rxd[i] = v;
    repeat (128) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input logic pbit, input logic stop);
    drive_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(i, d[k]);
    if (has_par(i)) drive_bit(i, pbit);
    drive_bit(i, stop);
    rxd[i] = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic host_read(input int i);
    @(posedge clk);
    #1 rd[i] = 1'b1;
    @(posedge clk);
    #1 rd[i] = 1'b0;
    model_read(i);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       pb, sb;
    int         u;

    // Reset
    model_reset();
    rstb = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_all(i, "reset");

    // Nominal frame and read
    settle(20);
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    model_frame(0, 8'hA5, 1'b0, 1'b1);
    settle(400);
    check_all(0, "nominal");
    host_read(0);
    check_all(0, "nominal_rd");

    // False start glitch, then framing error
    rxd[0] = 1'b0;
    repeat (24) @(posedge clk);
    #1 rxd[0] = 1'b1;
    settle(200);
    check_all(0, "glitch");
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    model_frame(0, 8'h3C, 1'b0, 1'b0);
    settle(400);
    check_all(0, "ferr");
    host_read(0);

    // Overrun
    send_frame(0, 8'h11, 1'b0, 1'b1);
    model_frame(0, 8'h11, 1'b0, 1'b1);
    settle(400);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    model_frame(0, 8'h22, 1'b0, 1'b1);
    settle(400);
    check_all(0, "overrun");
    host_read(0);
    check_all(0, "overrun_rd");

    // Even parity: correct then wrong parity bit
    send_frame(1, 8'h07, 1'b1, 1'b1);
    model_frame(1, 8'h07, 1'b1, 1'b1);
    settle(400);
    check_all(1, "par_ok");
    host_read(1);
    send_frame(1, 8'h07, 1'b0, 1'b1);
    model_frame(1, 8'h07, 1'b0, 1'b1);
    settle(400);
    check_all(1, "par_bad");
    host_read(1);

    // Read on the exact load cycle: start bit launched right after a strobe rise
    send_frame(0, 8'h55, 1'b0, 1'b1);
    model_frame(0, 8'h55, 1'b0, 1'b1);
    settle(400);
    @(posedge bclkx8);
    fork
      send_frame(0, 8'hAA, 1'b0, 1'b1);
      begin
        repeat (1232) @(posedge clk);
        #1 rd[0] = 1'b1;
        @(posedge clk);
        #1 rd[0] = 1'b0;
      end
    join
    model_read(0);
    model_frame(0, 8'hAA, 1'b0, 1'b1);
    settle(400);
    check_all(0, "rd_load");
    host_read(0);

    // Break: 0x00 with ferr, then a re-detected frame (0xFE) overruns
    rxd[0] = 1'b0;
    repeat (1500) @(posedge clk);
    #1 rxd[0] = 1'b1;
    model_frame(0, 8'h00, 1'b0, 1'b0);
    model_frame(0, 8'hFE, 1'b0, 1'b1);
    settle(3000);
    check_all(0, "break");
    host_read(0);

    // Randomized frames across all three receivers
    for (int n = 0; n < 16; n++) begin
      u  = int'($urandom_range(0, 2));
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(u, d, pb, sb);
      model_frame(u, d, pb, sb);
      settle(400 + int'($urandom_range(0, 63)));
      check_all(u, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) host_read(u);
    end

    // Reset in the middle of a data field abandons the frame
    send_frame(1, 8'h5A, 1'b0, 1'b1);
    model_frame(1, 8'h5A, 1'b0, 1'b1);
    settle(400);
    fork
      send_frame(0, 8'hFF, 1'b0, 1'b1);
      begin
        repeat (500) @(posedge clk);
        @(negedge clk);
        check_val("midframe_busy", 32'(busy[0]), 32'h1);
        @(posedge clk);
        #1 rstb = 1'b1;
        @(posedge clk);
        #1 rstb = 1'b0;
        model_reset();
      end
    join
    settle(400);
    for (int i = 0; i < 3; i++) check_all(i, "midreset");

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
